// File: rtl/hu_memctl.sv
// Host-to-asynchronous-memory strobe sequencer for the shared SRAM/EPROM bus.
// All pad-side outputs are registered from the next-state decode.
module hu_memctl #(
  parameter int unsigned RD_CYC   = 2,
  parameter int unsigned WR_CYC   = 1,
  parameter int unsigned TURN_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [19:0] addr,
  input  logic [7:0]  wdata,
  output logic        ack,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic [18:0] mem_a,
  output logic [7:0]  mem_d_o,
  output logic        mem_d_oe,
  input  logic [7:0]  mem_d_i,
  output logic        ncs_ram,
  output logic        ncs_rom,
  output logic        noe,
  output logic        nwe
);

  localparam int unsigned M1 = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
  localparam int unsigned M2 = (M1 > TURN_CYC) ? M1 : TURN_CYC;
  localparam int CW = (M2 < 2) ? 1 : $clog2(M2);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WSU, S_WR, S_WH, S_DONE, S_TURN
  } state_t;

  state_t        state_q, state_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic          op_rd_q, op_rd_nxt;
  logic          op_err_q, op_err_nxt;
  logic          op_rom_q, op_rom_nxt;
  logic          take, rd_last;
  logic          act_nxt;

  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    op_rd_nxt  = op_rd_q;
    op_err_nxt = op_err_q;
    op_rom_nxt = op_rom_q;
    take       = 1'b0;
    rd_last    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          take       = 1'b1;
          op_rd_nxt  = ~we;
          op_rom_nxt = addr[19];
          op_err_nxt = we & addr[19];
          if (!we) begin
            state_nxt = S_RD;
            cnt_nxt   = CW'(RD_CYC - 1);
          end else if (addr[19]) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_WSU;
          end
        end
      end
      S_RD: begin
        if (cnt_q == '0) begin
          state_nxt = S_DONE;
          rd_last   = 1'b1;
        end else begin
          cnt_nxt = cnt_q - CW'(1);
        end
      end
      S_WSU: begin
        state_nxt = S_WR;
        cnt_nxt   = CW'(WR_CYC - 1);
      end
      S_WR: begin
        if (cnt_q == '0) state_nxt = S_WH;
        else             cnt_nxt   = cnt_q - CW'(1);
      end
      S_WH: state_nxt = S_DONE;
      S_DONE: begin
        if (op_rd_q && TURN_CYC != 0) begin
          state_nxt = S_TURN;
          cnt_nxt   = CW'(TURN_CYC - 1);
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_TURN: begin
        if (cnt_q == '0) state_nxt = S_IDLE;
        else             cnt_nxt   = cnt_q - CW'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
    act_nxt = state_nxt inside {S_RD, S_WSU, S_WR, S_WH};
  end

  // Strobes are decoded from the next state so each pad register lines up
  // with the state it belongs to; ack/err trail DONE by one registered cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_rd_q  <= 1'b0;
      op_err_q <= 1'b0;
      op_rom_q <= 1'b0;
      ncs_ram  <= 1'b1;
      ncs_rom  <= 1'b1;
      noe      <= 1'b1;
      nwe      <= 1'b1;
      mem_d_oe <= 1'b0;
      busy     <= 1'b0;
      ack      <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      mem_a    <= '0;
      mem_d_o  <= '0;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      op_rd_q  <= op_rd_nxt;
      op_err_q <= op_err_nxt;
      op_rom_q <= op_rom_nxt;
      ncs_ram  <= ~(act_nxt & ~op_rom_nxt);
      ncs_rom  <= ~(act_nxt & op_rom_nxt);
      noe      <= (state_nxt != S_RD);
      nwe      <= (state_nxt != S_WR);
      mem_d_oe <= state_nxt inside {S_WSU, S_WR, S_WH};
      busy     <= (state_nxt != S_IDLE);
      ack      <= (state_q == S_DONE);
      err      <= (state_q == S_DONE) & op_err_q;
      if (rd_last) rdata <= mem_d_i;
      if (take && !(we && addr[19]))
        mem_a <= addr[19] ? {1'b0, addr[17:0]} : addr[18:0];
      if (take && we && !addr[19]) mem_d_o <= wdata;
    end
  end

endmodule

// File: tb/tb_hu_memctl.sv
// Bench for hu_memctl: three parameter sets, each with a cycle-timeline model
// derived from the access latency rules, a device model and directed accesses.
module tb_hu_memctl;

  localparam int N = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ndone = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int unsigned RD = (g == 0) ? 2 : (g == 1) ? 1 : 4;
    localparam int unsigned WR = (g == 0) ? 1 : (g == 1) ? 1 : 3;
    localparam int unsigned TN = (g == 0) ? 1 : (g == 1) ? 0 : 2;

    logic        rst = 1'b1, req = 1'b0, we = 1'b0;
    logic [19:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic        ack, err, busy, mem_d_oe, ncs_ram, ncs_rom, noe, nwe;
    logic [7:0]  rdata, mem_d_o;
    logic [7:0]  mem_d_i = 8'hEE;
    logic [18:0] mem_a;

    hu_memctl #(.RD_CYC(RD), .WR_CYC(WR), .TURN_CYC(TN)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack), .err(err), .rdata(rdata), .busy(busy), .mem_a(mem_a),
      .mem_d_o(mem_d_o), .mem_d_oe(mem_d_oe), .mem_d_i(mem_d_i),
      .ncs_ram(ncs_ram), .ncs_rom(ncs_rom), .noe(noe), .nwe(nwe)
    );

    // Asynchronous memory devices: write on the rising nwe, drive while selected.
    logic [7:0] dev_ram [int];
    logic [7:0] dev_rom [int];
    logic       prev_nwe = 1'b1;
    initial begin
      dev_ram[32'h12345] = 8'hA5;
      dev_rom[32'h03FFF] = 8'h5A;
      forever begin
        @(negedge clk);
        if (prev_nwe === 1'b0 && nwe === 1'b1 && ncs_ram === 1'b0)
          dev_ram[int'(mem_a)] = mem_d_o;
        prev_nwe = nwe;
        if (noe === 1'b0 && ncs_ram === 1'b0)
          mem_d_i = dev_ram.exists(int'(mem_a)) ? dev_ram[int'(mem_a)] : 8'h00;
        else if (noe === 1'b0 && ncs_rom === 1'b0)
          mem_d_i = dev_rom.exists(int'(mem_a[17:0])) ? dev_rom[int'(mem_a[17:0])] : 8'h00;
        else
          mem_d_i = 8'hEE;
      end
    end

    // Expected value of every output for each cycle following edge e.
    bit          x_ncs_ram [N], x_ncs_rom [N], x_noe [N], x_nwe [N];
    bit          x_oe [N], x_ack [N], x_err [N], x_busy [N];
    logic [18:0] x_a [N];
    logic [7:0]  x_do [N], x_rd [N];
    logic [7:0]  ref_ram [int];
    logic [7:0]  ref_rom [int];
    int          e = 0, free_at = 0, e0 = 0, ka = 0;
    bit          started = 1'b0;
    logic [7:0]  rv;
    logic [18:0] ma;

    initial begin
      ref_ram[32'h12345] = 8'hA5;
      ref_rom[32'h03FFF] = 8'h5A;
      forever begin
        @(posedge clk);
        e++;
        if (rst) begin
          for (int c = e; c < N; c++) begin
            x_ncs_ram[c] = 1; x_ncs_rom[c] = 1; x_noe[c] = 1; x_nwe[c] = 1;
            x_oe[c] = 0; x_ack[c] = 0; x_err[c] = 0; x_busy[c] = 0;
            x_a[c] = '0; x_do[c] = '0; x_rd[c] = '0;
          end
          free_at = e + 1;
          started = 1'b1;
        end else if (started && req && e >= free_at) begin
          e0 = e;
          ma = addr[19] ? {1'b0, addr[17:0]} : addr[18:0];
          if (!we) begin
            for (int c = e0; c < e0 + int'(RD) && c < N; c++) begin
              x_noe[c] = 0;
              if (addr[19]) x_ncs_rom[c] = 0; else x_ncs_ram[c] = 0;
            end
            if (addr[19]) begin
              ka = int'(addr[17:0]);
              rv = ref_rom.exists(ka) ? ref_rom[ka] : 8'h00;
            end else begin
              ka = int'(addr[18:0]);
              rv = ref_ram.exists(ka) ? ref_ram[ka] : 8'h00;
            end
            for (int c = e0 + int'(RD); c < N; c++) x_rd[c] = rv;
            for (int c = e0; c < N; c++) x_a[c] = ma;
            if (e0 + int'(RD) + 1 < N) x_ack[e0 + int'(RD) + 1] = 1;
            free_at = e0 + int'(RD) + 2 + int'(TN);
          end else if (addr[19]) begin
            if (e0 + 1 < N) begin x_ack[e0 + 1] = 1; x_err[e0 + 1] = 1; end
            free_at = e0 + 2;
          end else begin
            for (int c = e0; c <= e0 + int'(WR) + 1 && c < N; c++) begin
              x_ncs_ram[c] = 0; x_oe[c] = 1;
            end
            for (int c = e0 + 1; c <= e0 + int'(WR) && c < N; c++) x_nwe[c] = 0;
            for (int c = e0; c < N; c++) begin x_a[c] = ma; x_do[c] = wdata; end
            if (e0 + int'(WR) + 3 < N) x_ack[e0 + int'(WR) + 3] = 1;
            ref_ram[int'(addr[18:0])] = wdata;
            free_at = e0 + int'(WR) + 4;
          end
          for (int c = e0; c <= free_at - 2 && c < N; c++) x_busy[c] = 1;
        end
      end
    end

    initial forever begin
      @(negedge clk);
      if (started && e < N) begin
        check($sformatf("c%0d@%0d ncs_ram", g, e), ncs_ram, x_ncs_ram[e]);
        check($sformatf("c%0d@%0d ncs_rom", g, e), ncs_rom, x_ncs_rom[e]);
        check($sformatf("c%0d@%0d noe", g, e), noe, x_noe[e]);
        check($sformatf("c%0d@%0d nwe", g, e), nwe, x_nwe[e]);
        check($sformatf("c%0d@%0d mem_d_oe", g, e), mem_d_oe, x_oe[e]);
        check($sformatf("c%0d@%0d ack", g, e), ack, x_ack[e]);
        check($sformatf("c%0d@%0d err", g, e), err, x_err[e]);
        check($sformatf("c%0d@%0d busy", g, e), busy, x_busy[e]);
        check($sformatf("c%0d@%0d mem_a", g, e), mem_a, x_a[e]);
        check($sformatf("c%0d@%0d mem_d_o", g, e), mem_d_o, x_do[e]);
        check($sformatf("c%0d@%0d rdata", g, e), rdata, x_rd[e]);
        check($sformatf("c%0d@%0d cs_excl", g, e), ncs_ram | ncs_rom, 1);
        check($sformatf("c%0d@%0d oe_we_excl", g, e), noe | nwe, 1);
      end
    end

    task automatic wait_idle();
      int k;
      k = 0;
      @(negedge clk);
      while (busy !== 1'b0 && k < 50) begin
        @(negedge clk);
        k++;
      end
    endtask

    task automatic acc(input logic w, input logic [19:0] a, input logic [7:0] d,
                       output int lat, output int noe_lo, output int nwe_lo,
                       output int any_lo, output logic [7:0] rd, output logic er);
      lat = -1; noe_lo = 0; nwe_lo = 0; any_lo = 0; rd = '0; er = 1'b0;
      wait_idle();
      req = 1'b1; we = w; addr = a; wdata = d;
      @(posedge clk);
      #1 req = 1'b0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (noe === 1'b0) noe_lo++;
        if (nwe === 1'b0) nwe_lo++;
        if (ncs_ram === 1'b0 || ncs_rom === 1'b0 || noe === 1'b0 || nwe === 1'b0 || mem_d_oe === 1'b1)
          any_lo++;
        if (ack === 1'b1) begin
          lat = i; rd = rdata; er = err;
          break;
        end
      end
    endtask

    initial begin
      int lat, nl, wl, al, nack, t;
      int at [4];
      logic [7:0] rd;
      logic er;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      acc(1'b0, 20'h12345, 8'h00, lat, nl, wl, al, rd, er);
      check($sformatf("c%0d rd_lat", g), lat, RD + 1);
      check($sformatf("c%0d rd_noe_cycles", g), nl, RD);
      check($sformatf("c%0d rd_data", g), rd, 8'hA5);
      check($sformatf("c%0d rd_err", g), er, 0);

      acc(1'b1, 20'h7FFFF, 8'h3C, lat, nl, wl, al, rd, er);
      check($sformatf("c%0d wr_lat", g), lat, WR + 3);
      check($sformatf("c%0d wr_nwe_cycles", g), wl, WR);
      check($sformatf("c%0d wr_err", g), er, 0);
      rd = dev_ram.exists(32'h7FFFF) ? dev_ram[32'h7FFFF] : 8'h00;
      check($sformatf("c%0d dev_get_7FFFF", g), rd, 8'h3C);

      acc(1'b0, 20'h7FFFF, 8'h00, lat, nl, wl, al, rd, er);
      check($sformatf("c%0d readback", g), rd, 8'h3C);

      acc(1'b0, 20'h83FFF, 8'h00, lat, nl, wl, al, rd, er);
      check($sformatf("c%0d rom_rd", g), rd, 8'h5A);
      check($sformatf("c%0d rom_addr", g), mem_a, 19'h03FFF);
      acc(1'b0, 20'hC3FFF, 8'h00, lat, nl, wl, al, rd, er);
      check($sformatf("c%0d rom_rd_a18", g), rd, 8'h5A);
      check($sformatf("c%0d rom_addr_a18", g), mem_a, 19'h03FFF);

      acc(1'b1, 20'h80010, 8'h99, lat, nl, wl, al, rd, er);
      check($sformatf("c%0d rom_wr_lat", g), lat, 1);
      check($sformatf("c%0d rom_wr_err", g), er, 1);
      check($sformatf("c%0d rom_wr_quiet", g), al, 0);
      check($sformatf("c%0d rom_wr_addr_kept", g), mem_a, 19'h03FFF);

      // Held request: four reads back to back.
      wait_idle();
      req = 1'b1; we = 1'b0; addr = 20'h12345;
      nack = 0; t = 0;
      while (nack < 4 && t < 200) begin
        @(negedge clk);
        t++;
        if (ack === 1'b1) begin
          at[nack] = t;
          nack++;
        end
      end
      req = 1'b0;
      check($sformatf("c%0d b2b_acks", g), nack, 4);
      for (int i = 1; i < 4; i++)
        check($sformatf("c%0d b2b_gap%0d", g, i), at[i] - at[i-1], RD + 2 + TN);

      // Reset while nwe is low.
      wait_idle();
      req = 1'b1; we = 1'b1; addr = 20'h00100; wdata = 8'h77;
      @(posedge clk);
      #1 req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check($sformatf("c%0d mid_wr_nwe", g), nwe, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check($sformatf("c%0d abort_strobes", g), {ncs_ram, ncs_rom, noe, nwe}, 4'hF);
      check($sformatf("c%0d abort_oe", g), mem_d_oe, 0);
      nack = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (ack === 1'b1) nack++;
      end
      check($sformatf("c%0d abort_no_ack", g), nack, 0);
      acc(1'b0, 20'h7FFFF, 8'h00, lat, nl, wl, al, rd, er);
      check($sformatf("c%0d post_abort_lat", g), lat, RD + 1);
      check($sformatf("c%0d post_abort_rd", g), rd, 8'h3C);

      ndone++;
    end
  end

  initial begin
    int k;
    k = 0;
    while (ndone < 3 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (ndone < 3) begin
      bad++;
      $display("FAIL timeout: configs done %0d expected 3", ndone);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hu_memctl.md
# hu_memctl

Synchronous host-to-asynchronous-memory controller for HULOGIC. Turns single-cycle host read/write requests into correctly timed nCS/nOE/nWE strobe sequences for the 512Kx8 program/data SRAM and the 256Kx8 boot EPROM on the shared external 8-bit bus. Sits directly upstream of both memory devices, between the internal bus arbiter and the FPGA pads. All strobe timing is a whole number of clock cycles, set by parameters.

## Interface
- RD_CYC, 2: cycles nOE/nCS held low for a read (≥1); 2 cycles at 50 ns covers 70 ns access.
- WR_CYC, 1: cycles nWE held low (≥1); ≥50 ns write pulse.
- TURN_CYC, 1: idle cycles after a read before the next access starts (≥0); covers 25 ns output disable.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  access request, sampled only in IDLE.
- we  in  1  1 = write, 0 = read; captured with req.
- addr  in  20  bit 19: 0 = SRAM, 1 = EPROM; bits 18:0 = device address.
- wdata  in  8  write data; captured with req.
- ack  out  1  one-cycle completion pulse.
- err  out  1  valid with ack; 1 = write to EPROM rejected.
- rdata  out  8  read data; valid with ack, held until next read completes.
- busy  out  1  high in every state except IDLE.
- mem_a  out  19  memory address bus.
- mem_d_o  out  8  data bus output value.
- mem_d_oe  out  1  1 = FPGA drives data bus.
- mem_d_i  in  8  data bus input value.
- ncs_ram  out  1  SRAM chip select, active low.
- ncs_rom  out  1  EPROM chip select, active low.
- noe  out  1  output enable, active low.
- nwe  out  1  write enable, active low.

## Operation
- All memory-side outputs are registers; no combinational path from req/addr to pads.
- States: IDLE, RD, WSU, WR, WH, DONE, TURN.
- IDLE: on req=1 capture we/addr/wdata. Read → RD. Write to SRAM → WSU. Write to EPROM → DONE with err=1; no strobes and no bus activity.
- RD: selected ncs low, noe low, mem_a valid, RD_CYC cycles. mem_d_i is registered into rdata on the edge that ends the last RD cycle → DONE.
- WSU (1 cycle): ncs_ram low, mem_a valid, mem_d_oe=1, nwe high → WR.
- WR (WR_CYC cycles): nwe low, address, data and ncs held → WH.
- WH (1 cycle): nwe high, address, data, mem_d_oe and ncs_ram still held (address and data hold) → DONE.
- DONE (1 cycle): ack=1, all strobes high, mem_d_oe=0. After a read → TURN, or IDLE if TURN_CYC=0. After a write or rejected write → IDLE.
- TURN (TURN_CYC cycles): strobes high, req ignored → IDLE.
- EPROM address: mem_a[17:0]=addr[17:0], mem_a[18] forced 0.
- mem_a and mem_d_o keep their last value in IDLE. They do not return to 0.
- req high in DONE or TURN is ignored. It is taken only once the block is back in IDLE, so a held req produces back-to-back accesses.
- ncs_ram and ncs_rom are never low in the same cycle. nwe and noe are never low in the same cycle. mem_d_oe=1 only in WSU, WR and WH.

## Timing
- Reset values: ncs_ram=ncs_rom=noe=nwe=1, mem_d_oe=0, ack=0, err=0, busy=0, rdata=0, mem_a=0, mem_d_o=0, state IDLE.
- Reset mid-access aborts the access. On the edge where rst=1 is sampled, every strobe returns high and mem_d_oe returns to 0. No ack is issued.
- Read latency: req is sampled at edge E0; noe and ncs are low from E0 to E0+RD_CYC; ack is high in the cycle after edge E0+RD_CYC+1. The earliest next acceptance is edge E0+RD_CYC+2+TURN_CYC.
- Write latency: ack is high in the cycle after edge E0+WR_CYC+3. The earliest next acceptance is edge E0+WR_CYC+4.
- Rejected EPROM write: ack=1 and err=1 one cycle after acceptance.
- busy rises in the cycle after acceptance and falls on return to IDLE.

## Test plan
- SRAM read, defaults, model preloaded 0x12345 = 0xA5 -> noe and ncs_ram low for exactly 2 cycles; ack after 3 cycles; rdata = 0xA5; err = 0; then 1 turnaround cycle.
- SRAM write 0x7FFFF = 0x3C, then read back -> nwe low 1 cycle; data and address stable 1 cycle either side of nwe; model get(0x7FFFF) = 0x3C; read returns 0x3C.
- EPROM read at addr 0x83FFF (preload 0x3FFF = 0x5A) -> ncs_rom low, mem_a[18] = 0, rdata = 0x5A; write to 0x80010 -> ack with err = 1 and no strobe activity.
- req held high for 4 back-to-back reads -> 4 ack pulses spaced RD_CYC+2+TURN_CYC cycles apart; ncs_ram and ncs_rom never low together.
- rst asserted in the middle of WR with WR_CYC = 3 -> all strobes high and mem_d_oe = 0 the next cycle; no ack; the next access completes normally.
- Parameter sweep RD_CYC = 1/4, WR_CYC = 1/3, TURN_CYC = 0/2 -> latencies match the formulas under Timing; model timing checks report no violations.
